// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the main-memory bus initiator: state encodings and
// default bus/timeout sizing.
package mem_access_ctrl_pkg;

  localparam int DATAWIDTH_BUS_DEF  = 32;
  localparam int TIMEOUT_CYCLES_DEF = 15;
  localparam int TIMEOUT_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_timeout_counter.sv
// ACK wait timer: loaded with LIMIT-1 on clear, counts down while enabled and
// holds at zero; tc flags the last permitted wait cycle.
module mem_access_timeout_counter
  import mem_access_ctrl_pkg::*;
#(
  parameter int WIDTH = TIMEOUT_WIDTH_DEF,
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Main-memory bus initiator: one read or write at a time, strobes held until
// ACK, with a bounded wait that converts a missing ACK into an error pulse.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for Req; request fields latched on acceptance
//   ST_ACCESS | address/data/strobe driven, waiting for ACK or timeout
//   ST_DONE   | one-cycle Done pulse, strobes low
//   ST_ERROR  | one-cycle Error pulse, strobes low, RData untouched
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = DATAWIDTH_BUS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMEOUT_WIDTH  = TIMEOUT_WIDTH_DEF
) (
  input  logic                     MEM_ACCESS_CTRL_CLOCK_50,
  input  logic                     MEM_ACCESS_CTRL_ResetInLow_In,
  input  logic                     MEM_ACCESS_CTRL_Req_In,
  input  logic                     MEM_ACCESS_CTRL_Write_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_Addr_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_WData_InBus,
  output logic                     MEM_ACCESS_CTRL_Busy_Out,
  output logic                     MEM_ACCESS_CTRL_Done_Out,
  output logic                     MEM_ACCESS_CTRL_Error_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_RData_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MemA_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MemB_OutBus,
  output logic                     MEM_ACCESS_CTRL_MemRD_Out,
  output logic                     MEM_ACCESS_CTRL_MemWRMain_Out,
  input  logic                     MEM_ACCESS_CTRL_MemACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ACCESS_CTRL_MemData_InBus
);

  state_t                   state, state_n;
  logic [DATAWIDTH_BUS-1:0] addr_q, wdata_q, rdata_q;
  logic                     wr_q;
  logic                     accept, in_access, ack_hit, timeout_tc;

  assign accept    = (state == ST_IDLE) && MEM_ACCESS_CTRL_Req_In;
  assign in_access = (state == ST_ACCESS);
  assign ack_hit   = in_access && MEM_ACCESS_CTRL_MemACK_In;

  mem_access_timeout_counter #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (MEM_ACCESS_CTRL_CLOCK_50),
    .rst_n  (MEM_ACCESS_CTRL_ResetInLow_In),
    .clear  (accept),
    .enable (in_access && !MEM_ACCESS_CTRL_MemACK_In),
    .tc     (timeout_tc)
  );

  always_ff @(posedge MEM_ACCESS_CTRL_CLOCK_50 or negedge MEM_ACCESS_CTRL_ResetInLow_In) begin
    if (!MEM_ACCESS_CTRL_ResetInLow_In) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ACK is checked before the timeout so a late ACK still completes the access
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (MEM_ACCESS_CTRL_Req_In) state_n = ST_ACCESS;
      ST_ACCESS: begin
        if (MEM_ACCESS_CTRL_MemACK_In) state_n = ST_DONE;
        else if (timeout_tc)           state_n = ST_ERROR;
      end
      ST_DONE:   state_n = ST_IDLE;
      ST_ERROR:  state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge MEM_ACCESS_CTRL_CLOCK_50 or negedge MEM_ACCESS_CTRL_ResetInLow_In) begin
    if (!MEM_ACCESS_CTRL_ResetInLow_In) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= MEM_ACCESS_CTRL_Addr_InBus;
        wdata_q <= MEM_ACCESS_CTRL_WData_InBus;
        wr_q    <= MEM_ACCESS_CTRL_Write_In;
      end
      if (ack_hit && !wr_q) begin
        rdata_q <= MEM_ACCESS_CTRL_MemData_InBus;
      end
    end
  end

  assign MEM_ACCESS_CTRL_Busy_Out      = (state != ST_IDLE);
  assign MEM_ACCESS_CTRL_Done_Out      = (state == ST_DONE);
  assign MEM_ACCESS_CTRL_Error_Out     = (state == ST_ERROR);
  assign MEM_ACCESS_CTRL_RData_OutBus  = rdata_q;
  assign MEM_ACCESS_CTRL_MemA_OutBus   = addr_q;
  assign MEM_ACCESS_CTRL_MemB_OutBus   = wdata_q;
  assign MEM_ACCESS_CTRL_MemRD_Out     = in_access && !wr_q;
  assign MEM_ACCESS_CTRL_MemWRMain_Out = in_access && wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a ROM responder with programmable ACK delay,
// a table of transactions, and hand-written reset / stray-ACK sequences.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wr;
  logic [31:0] addr, wdata;
  logic        busy, done, error, mem_rd, mem_wr, mem_ack;
  logic [31:0] rdata, mem_a, mem_b, mem_data;
  logic        strobe;
  logic        ack_force;
  int          ack_delay;
  int          strobe_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .MEM_ACCESS_CTRL_CLOCK_50      (clk),
    .MEM_ACCESS_CTRL_ResetInLow_In (rst_n),
    .MEM_ACCESS_CTRL_Req_In        (req),
    .MEM_ACCESS_CTRL_Write_In      (wr),
    .MEM_ACCESS_CTRL_Addr_InBus    (addr),
    .MEM_ACCESS_CTRL_WData_InBus   (wdata),
    .MEM_ACCESS_CTRL_Busy_Out      (busy),
    .MEM_ACCESS_CTRL_Done_Out      (done),
    .MEM_ACCESS_CTRL_Error_Out     (error),
    .MEM_ACCESS_CTRL_RData_OutBus  (rdata),
    .MEM_ACCESS_CTRL_MemA_OutBus   (mem_a),
    .MEM_ACCESS_CTRL_MemB_OutBus   (mem_b),
    .MEM_ACCESS_CTRL_MemRD_Out     (mem_rd),
    .MEM_ACCESS_CTRL_MemWRMain_Out (mem_wr),
    .MEM_ACCESS_CTRL_MemACK_In     (mem_ack),
    .MEM_ACCESS_CTRL_MemData_InBus (mem_data)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h9080_200A;
      32'd1:   return 32'h8A80_2001;
      32'd2:   return 32'h24A0_0003;
      32'd3:   return 32'h0C00_0010;
      default: return 32'h0100_0000;
    endcase
  endfunction

  // Responder: ACK after ack_delay strobe cycles; ack_delay < 0 never acks
  assign strobe   = mem_rd | mem_wr;
  assign mem_data = rom(mem_a);
  assign mem_ack  = ack_force | (strobe && (ack_delay >= 0) && (strobe_cnt >= ack_delay));

  always @(posedge clk) begin
    if (strobe) strobe_cnt <= strobe_cnt + 1;
    else        strobe_cnt <= 0;
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_delay;
    logic        poke;
    int          exp_done;
    int          exp_error;
    int          exp_cycles;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int acc, dn, er, bad, cyc;
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    ack_delay = v.ack_delay;
    req = 1'b1; wr = v.write; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1;
    req = 1'b0; addr = 32'hFFFF_FFF0; wdata = 32'h5555_AAAA; wr = ~v.write;
    acc = 0; dn = 0; er = 0; bad = 0; cyc = 0;
    while (dn == 0 && er == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done)  dn++;
      if (error) er++;
      if (mem_rd && mem_wr) bad++;
      if ((done || error) && strobe) bad++;
      if (strobe) begin
        acc++;
        if (mem_a !== v.addr || !busy || mem_rd !== !v.write || mem_wr !== v.write) bad++;
        if (v.write && mem_b !== v.wdata) bad++;
      end
      if (v.poke && strobe) begin
        req = 1'b1; addr = 32'h0000_0003;
      end else begin
        req = 1'b0;
      end
    end
    chk({tag, "_done"},     32'(dn),  32'(v.exp_done));
    chk({tag, "_error"},    32'(er),  32'(v.exp_error));
    chk({tag, "_access"},   32'(acc), 32'(v.exp_cycles));
    chk({tag, "_latency"},  32'(cyc), 32'(v.exp_cycles + 1));
    chk({tag, "_bus_bad"},  32'(bad), 32'd0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_pulse"},     {30'd0, done, error}, 32'd0);
    @(negedge clk);
    chk({tag, "_no_queue"},  {31'd0, busy}, 32'd0);
    chk({tag, "_rdata"},     rdata, v.exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd, ne;
    vecs[0] = '{write:1'b0, addr:32'd0,  wdata:32'h0,         ack_delay:0,  poke:1'b0,
                exp_done:1, exp_error:0, exp_cycles:1,  exp_rdata:32'h9080_200A};
    vecs[1] = '{write:1'b0, addr:32'd1,  wdata:32'h0,         ack_delay:0,  poke:1'b0,
                exp_done:1, exp_error:0, exp_cycles:1,  exp_rdata:32'h8A80_2001};
    vecs[2] = '{write:1'b0, addr:32'd14, wdata:32'h0,         ack_delay:0,  poke:1'b0,
                exp_done:1, exp_error:0, exp_cycles:1,  exp_rdata:32'h0100_0000};
    vecs[3] = '{write:1'b1, addr:32'd5,  wdata:32'hDEAD_BEEF, ack_delay:0,  poke:1'b0,
                exp_done:1, exp_error:0, exp_cycles:1,  exp_rdata:32'h0100_0000};
    vecs[4] = '{write:1'b0, addr:32'd2,  wdata:32'h0,         ack_delay:3,  poke:1'b1,
                exp_done:1, exp_error:0, exp_cycles:4,  exp_rdata:32'h24A0_0003};
    vecs[5] = '{write:1'b1, addr:32'd7,  wdata:32'h1234_5678, ack_delay:3,  poke:1'b1,
                exp_done:1, exp_error:0, exp_cycles:4,  exp_rdata:32'h24A0_0003};
    vecs[6] = '{write:1'b0, addr:32'd3,  wdata:32'h0,         ack_delay:-1, poke:1'b0,
                exp_done:0, exp_error:1, exp_cycles:15, exp_rdata:32'h24A0_0003};
    vecs[7] = '{write:1'b0, addr:32'd0,  wdata:32'h0,         ack_delay:0,  poke:1'b0,
                exp_done:1, exp_error:0, exp_cycles:1,  exp_rdata:32'h9080_200A};

    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    ack_force = 1'b0; ack_delay = 0;
    #12;
    chk("reset_busy",  {31'd0, busy}, 32'd0);
    chk("reset_pulse", {30'd0, done, error}, 32'd0);
    chk("reset_strb",  {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mema",  mem_a, 32'd0);
    chk("reset_memb",  mem_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Stray ACK while idle must not start, finish or capture anything
    @(negedge clk);
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_busy",  {31'd0, busy}, 32'd0);
    chk("stray_ack_pulse", {30'd0, done, error}, 32'd0);
    chk("stray_ack_rdata", rdata, 32'h9080_200A);
    ack_force = 1'b0;

    // Reset asserted in the middle of an ACCESS
    @(negedge clk);
    ack_delay = -1;
    req = 1'b1; wr = 1'b0; addr = 32'd1;
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_pre_rd", {31'd0, mem_rd}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd",    {31'd0, mem_rd}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy},   32'd0);
    chk("mid_rst_rdata", rdata,           32'd0);
    chk("mid_rst_mema",  mem_a,           32'd0);
    nd = 0; ne = 0;
    repeat (3) begin
      @(negedge clk);
      if (done)  nd++;
      if (error) ne++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done)  nd++;
      if (error) ne++;
    end
    chk("mid_rst_no_done",  32'(nd), 32'd0);
    chk("mid_rst_no_error", 32'(ne), 32'd0);
    run_vec('{write:1'b0, addr:32'd1, wdata:32'h0, ack_delay:0, poke:1'b0,
              exp_done:1, exp_error:0, exp_cycles:1, exp_rdata:32'h8A80_2001}, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
